// File: rtl/uart_rx_fifo_if.sv
// Bundle between uart_top / host logic and uart_rx_fifo.
// UART_RX_FIFO_DROP_CNT_EN adds the drop_cnt signal.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;

  modport master (
    output rx_rdy, rx_data, rd_en, ovf_clr,
    input  rx_rdy_clr, rd_data, rd_valid, empty, full, count, overflow, drop_cnt
  );
  modport slave (
    input  rx_rdy, rx_data, rd_en, ovf_clr,
    output rx_rdy_clr, rd_data, rd_valid, empty, full, count, overflow, drop_cnt
  );
`else
  modport master (
    output rx_rdy, rx_data, rd_en, ovf_clr,
    input  rx_rdy_clr, rd_data, rd_valid, empty, full, count, overflow
  );
  modport slave (
    input  rx_rdy, rx_data, rd_en, ovf_clr,
    output rx_rdy_clr, rd_data, rd_valid, empty, full, count, overflow
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer downstream of uart_top: captures rdy/data_out into a show-ahead FIFO.
// UART_RX_FIFO_DROP_CNT_EN adds a saturating 16-bit dropped-byte counter (drop_cnt).
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          capture;
  logic          clr_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          empty_w, full_w;
  logic          do_write, do_read, drop;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_LOW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          capture = 1'b1;
          state_d = CLR;
        end
      end
      CLR:      state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.rx_rdy) state_d = IDLE;
      default:  state_d = WAIT_LOW;
    endcase
  end

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

  // A read in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign do_read  = bus.rd_en && !empty_w;
  assign do_write = capture && (!full_w || bus.rd_en);
  assign drop     = capture && full_w && !bus.rd_en;

  always_ff @(posedge clk) begin
    if (rst) clr_q <= 1'b0;
    else     clr_q <= capture;
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW+1)'(do_write) - (AW+1)'(do_read);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              overflow_q <= 1'b0;
    else if (drop)        overflow_q <= 1'b1;
    else if (bus.ovf_clr) overflow_q <= 1'b0;
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (bus.ovf_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.rx_rdy_clr = clr_q;
  assign bus.count      = count_q;
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.rd_valid   = !empty_w;
  assign bus.rd_data    = empty_w ? 8'h00 : mem[rd_ptr];
  assign bus.overflow   = overflow_q;

endmodule
